// File: rtl/bpred_table_arbiter.sv
// Table of 2-bit saturating branch counters in a single-access array, shared between a
// 1-cycle lookup port and a read-modify-write update port. Macro BPRED_TABLE_FWD_EN enables update forwarding.
module bpred_table_arbiter #(
   parameter int         IDX_W    = 4,
   parameter logic [1:0] INIT_CTR = 2'b00,
   parameter int         MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lookup_valid,
   output logic             lookup_ready,
   input  logic [IDX_W-1:0] lookup_index,
   output logic             pred_valid,
   output logic             pred_taken,
   input  logic             update_valid,
   output logic             update_ready,
   input  logic [IDX_W-1:0] update_index,
   input  logic             update_taken,
   output logic             busy
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // the requester holds its payload stable while valid is high and ready is low.

   localparam int DEPTH = 1 << IDX_W;
   localparam int WCW   = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR} state_t;

   state_t           state, state_nx;
   logic [1:0]       ctr_tbl [DEPTH];
   logic             buf_full, buf_taken;
   logic [IDX_W-1:0] buf_idx;
   logic [1:0]       tmp;
   logic [WCW-1:0]   wait_cnt;
   logic             upd_win, lookup_fire, lk_taken;
   logic [IDX_W-1:0] rd_idx;
   logic [1:0]       rd_ctr, wr_ctr;

   function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'd1;
      else    return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   always_comb begin
      state_nx     = state;
      upd_win      = 1'b0;
      lookup_ready = 1'b0;
      case (state)
         IDLE: begin
            // a pending update takes the array when nobody looks up or it has starved long enough
            upd_win      = buf_full && (!lookup_valid || wait_cnt == WAIT_MAX);
            lookup_ready = !upd_win;
            if (upd_win) state_nx = UPD_RD;
         end
         UPD_RD:  state_nx = UPD_WR;
         UPD_WR:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign update_ready = !buf_full;
   assign busy         = buf_full || (state != IDLE);
   assign lookup_fire  = lookup_valid && lookup_ready;
   assign rd_idx       = upd_win ? buf_idx : lookup_index;
   assign rd_ctr       = ctr_tbl[rd_idx];
   assign wr_ctr       = sat_step(tmp, buf_taken);

`ifdef BPRED_TABLE_FWD_EN
   logic [1:0] fwd_ctr;
   always_comb begin
      fwd_ctr  = sat_step(rd_ctr, buf_taken);
      lk_taken = (buf_full && buf_idx == lookup_index) ? fwd_ctr[1] : rd_ctr[1];
   end
`else
   assign lk_taken = rd_ctr[1];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         buf_full   <= 1'b0;
         buf_idx    <= '0;
         buf_taken  <= 1'b0;
         tmp        <= '0;
         wait_cnt   <= '0;
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ctr_tbl[i] <= INIT_CTR;
      end else begin
         state      <= state_nx;
         pred_valid <= lookup_fire;
         if (lookup_fire) pred_taken <= lk_taken;
         if (upd_win) begin
            tmp      <= rd_ctr;
            wait_cnt <= '0;
         end else if (state == IDLE && buf_full && lookup_valid) begin
            wait_cnt <= wait_cnt + WCW'(1);
         end
         // the buffer frees on the write edge; a new capture waits for the next cycle
         if (state == UPD_RD) begin
            ctr_tbl[buf_idx] <= wr_ctr;
            buf_full         <= 1'b0;
         end else if (update_valid && update_ready) begin
            buf_full  <= 1'b1;
            buf_idx   <= update_index;
            buf_taken <= update_taken;
         end
      end
   end

endmodule

// File: tb/tb_bpred_table_arbiter.sv
// Bench for bpred_table_arbiter: directed scenarios plus randomized traffic against a counter-table model.
module tb_bpred_table_arbiter;
   localparam int IDX_W = 4;
   localparam int DEPTH = 16;
   localparam int MAX_WAIT = 4;
   localparam logic [1:0] INIT_CTR = 2'b00;
`ifdef BPRED_TABLE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic lookup_valid = 1'b0, lookup_ready;
   logic [IDX_W-1:0] lookup_index = '0;
   logic pred_valid, pred_taken;
   logic update_valid = 1'b0, update_ready, update_taken = 1'b0;
   logic [IDX_W-1:0] update_index = '0;
   logic busy;

   always #5 clk = ~clk;

   bpred_table_arbiter #(.IDX_W(IDX_W), .INIT_CTR(INIT_CTR), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_index(lookup_index),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .update_valid(update_valid), .update_ready(update_ready), .update_index(update_index),
      .update_taken(update_taken), .busy(busy)
   );

   int n_pass = 0;
   int n_total = 0;

   // model: counter values, one pending update, its lost-arbitration count and remaining busy cycles
   int  m_ctr [DEPTH];
   bit  m_buf, m_bt;
   int  m_bidx, m_lost, m_phase, m_upd_accepts;
   bit  e_lready, e_uready, e_busy, e_win;
   logic [0:0] exp_q[$];

   function automatic int sat_step(input int c, input bit up);
      if (up) return (c >= 3) ? 3 : c + 1;
      else    return (c <= 0) ? 0 : c - 1;
   endfunction

   task automatic model_pre();
      e_uready = !m_buf;
      e_busy   = m_buf || (m_phase != 0);
      e_win    = (m_phase == 0) && m_buf && (!lookup_valid || m_lost >= MAX_WAIT);
      e_lready = (m_phase == 0) && !e_win;
   endtask

   task automatic model_edge();
      int nc;
      if (reset) begin
         foreach (m_ctr[i]) m_ctr[i] = int'(INIT_CTR);
         m_buf = 0; m_lost = 0; m_phase = 0;
         return;
      end
      if (lookup_valid && e_lready) begin
         nc = m_ctr[lookup_index];
         if (FWD && m_buf && m_bidx == int'(lookup_index)) nc = sat_step(nc, m_bt);
         exp_q.push_back(1'(nc >= 2));
      end
      case (m_phase)
         0: if (e_win) begin m_phase = 2; m_lost = 0; end
            else if (m_buf && lookup_valid) m_lost++;
         2: begin m_ctr[m_bidx] = sat_step(m_ctr[m_bidx], m_bt); m_buf = 0; m_phase = 1; end
         default: m_phase = 0;
      endcase
      if (update_valid && e_uready) begin
         m_buf = 1; m_bidx = int'(update_index); m_bt = update_taken; m_upd_accepts++;
      end
   endtask

   // drive one cycle's inputs and stop at the falling edge where outputs are sampled
   task automatic drive(input bit lv, input int li, input bit uv, input int ui, input bit ut);
      lookup_valid = lv; lookup_index = li[IDX_W-1:0];
      update_valid = uv; update_index = ui[IDX_W-1:0]; update_taken = ut;
      model_pre();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      exp_q.delete();
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin drive(0, 0, 0, 0, 0); tick(); end
   endtask

   task automatic do_reset();
      reset = 1'b1; idle(2); reset = 1'b0;
   endtask

   task automatic send_update(input int idx, input bit t);
      int k = 0;
      while (m_buf && k < 20) begin idle(1); k++; end
      drive(0, 0, 1, idx, t); tick();
   endtask

   task automatic drain();
      int k = 0;
      while ((m_buf || m_phase != 0) && k < 20) begin idle(1); k++; end
   endtask

   task automatic lookup_one(input int idx, output logic pv, output logic pt);
      drive(1, idx, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      pv = pred_valid; pt = pred_taken;
      tick();
   endtask

   task automatic test_reset();
      logic pv, pt;
      reset = 1'b1; idle(2); reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      n_total++; if (lookup_ready !== 1'b1) $display("FAIL reset_lookup_ready: got %b expected 1", lookup_ready); else n_pass++;
      n_total++; if (update_ready !== 1'b1) $display("FAIL reset_update_ready: got %b expected 1", update_ready); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (pred_valid !== 1'b0) $display("FAIL reset_pred_valid: got %b expected 0", pred_valid); else n_pass++;
      n_total++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); else n_pass++;
      tick();
      lookup_one(3, pv, pt);
      n_total++; if (pv !== 1'b1 || pt !== 1'b0) $display("FAIL lookup3: got valid %b taken %b expected 1 0", pv, pt); else n_pass++;
      drive(0, 0, 0, 0, 0);
      n_total++; if (pred_valid !== 1'b0) $display("FAIL pred_pulse_end: got %b expected 0", pred_valid); else n_pass++;
      tick();
   endtask

   task automatic test_saturation();
      logic pv, pt;
      do_reset();
      repeat (2) send_update(5, 1);
      drain(); lookup_one(5, pv, pt);
      n_total++; if (pv !== 1'b1 || pt !== 1'b1) $display("FAIL sat_two_taken: got %b %b expected 1 1", pv, pt); else n_pass++;
      repeat (3) send_update(5, 1);
      send_update(5, 0);
      drain(); lookup_one(5, pv, pt);
      n_total++; if (pt !== 1'b1) $display("FAIL sat_top: got %b expected 1", pt); else n_pass++;
      repeat (3) send_update(5, 0);
      drain(); lookup_one(5, pv, pt);
      n_total++; if (pt !== 1'b0) $display("FAIL sat_bottom: got %b expected 0", pt); else n_pass++;
      send_update(5, 1);
      drain(); lookup_one(5, pv, pt);
      n_total++; if (pt !== 1'b0) $display("FAIL sat_after_bottom: got %b expected 0", pt); else n_pass++;
   endtask

   task automatic test_starvation();
      bit exp_lr [9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
      bit exp_ur [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
      bit exp_b  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
      bit exp_pv [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 1};
      do_reset();
      send_update(9, 1);
      for (int c = 0; c < 9; c++) begin
         drive(1, $urandom_range(0, 15), 0, 0, 0);
         n_total++; if (lookup_ready !== exp_lr[c]) $display("FAIL starve_lready c%0d: got %b expected %b", c, lookup_ready, exp_lr[c]); else n_pass++;
         n_total++; if (update_ready !== exp_ur[c]) $display("FAIL starve_uready c%0d: got %b expected %b", c, update_ready, exp_ur[c]); else n_pass++;
         n_total++; if (busy !== exp_b[c]) $display("FAIL starve_busy c%0d: got %b expected %b", c, busy, exp_b[c]); else n_pass++;
         n_total++; if (pred_valid !== exp_pv[c]) $display("FAIL starve_pvalid c%0d: got %b expected %b", c, pred_valid, exp_pv[c]); else n_pass++;
         tick();
      end
   endtask

   task automatic test_forward();
      logic pv, pt;
      do_reset();
      send_update(2, 1);
      drain();
      send_update(2, 1);
      drive(1, 2, 0, 0, 0);
      n_total++; if (lookup_ready !== 1'b1) $display("FAIL fwd_lready: got %b expected 1", lookup_ready); else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0);
      n_total++; if (pred_valid !== 1'b1 || pred_taken !== FWD) $display("FAIL fwd_pred: got %b %b expected 1 %b", pred_valid, pred_taken, FWD); else n_pass++;
      tick();
      drain(); lookup_one(2, pv, pt);
      n_total++; if (pt !== 1'b1) $display("FAIL fwd_after_write: got %b expected 1", pt); else n_pass++;
   endtask

   task automatic test_reset_mid_update();
      logic pv, pt;
      do_reset();
      repeat (2) send_update(7, 1);
      drain();
      send_update(7, 1);
      drive(0, 0, 0, 0, 0);
      n_total++; if (busy !== 1'b1 || lookup_ready !== 1'b0) $display("FAIL mid_win: got busy %b lready %b expected 1 0", busy, lookup_ready); else n_pass++;
      tick();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0); tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
      n_total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (update_ready !== 1'b1 || lookup_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b %b expected 1 1", update_ready, lookup_ready); else n_pass++;
      tick();
      lookup_one(7, pv, pt);
      n_total++; if (pv !== 1'b1 || pt !== INIT_CTR[1]) $display("FAIL mid_reset_ctr: got %b %b expected 1 %b", pv, pt, INIT_CTR[1]); else n_pass++;
   endtask

   task automatic test_random();
      logic pv, pt;
      int dut_acc = 0;
      do_reset();
      m_upd_accepts = 0;
      for (int c = 0; c < 300; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
               (c >= 150) ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         if (update_valid && update_ready) dut_acc++;
         n_total++; if (lookup_ready !== e_lready) $display("FAIL rnd_lready c%0d: got %b expected %b", c, lookup_ready, e_lready); else n_pass++;
         n_total++; if (update_ready !== e_uready) $display("FAIL rnd_uready c%0d: got %b expected %b", c, update_ready, e_uready); else n_pass++;
         n_total++; if (busy !== e_busy) $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, e_busy); else n_pass++;
         n_total++; if (pred_valid !== (exp_q.size() != 0)) $display("FAIL rnd_pvalid c%0d: got %b expected %b", c, pred_valid, exp_q.size() != 0); else n_pass++;
         if (exp_q.size() != 0 && pred_valid === 1'b1) begin
            n_total++; if (pred_taken !== exp_q[0]) $display("FAIL rnd_ptaken c%0d: got %b expected %b", c, pred_taken, exp_q[0]); else n_pass++;
         end
         tick();
      end
      drain();
      n_total++; if (dut_acc != m_upd_accepts) $display("FAIL rnd_update_count: got %0d expected %0d", dut_acc, m_upd_accepts); else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         bit e = (m_ctr[i] >= 2);
         lookup_one(i, pv, pt);
         n_total++; if (pv !== 1'b1 || pt !== e) $display("FAIL rnd_table idx%0d: got %b %b expected 1 %b", i, pv, pt, e); else n_pass++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_saturation();
      test_starvation();
      test_forward();
      test_reset_mid_update();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
